// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: ALU op-codes and the E-stage control bundle
// with its bubble value.
package mips_pkg;

    typedef enum logic [2:0] {
        ALU_AND = 3'b000,
        ALU_OR  = 3'b001,
        ALU_ADD = 3'b010,
        ALU_SUB = 3'b110,
        ALU_SLT = 3'b111
    } alu_op_e;

    typedef struct packed {
        logic    reg_write;
        logic    mem_to_reg;
        logic    mem_write;
        logic    alu_src;
        logic    reg_dst;
        alu_op_e alu_op;
    } ctrl_t;

    localparam ctrl_t CTRL_BUBBLE = '{
        reg_write:  1'b0,
        mem_to_reg: 1'b0,
        mem_write:  1'b0,
        alu_src:    1'b0,
        reg_dst:    1'b0,
        alu_op:     ALU_AND
    };

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard detection and fetch/decode stall generation for the ID/EX stage.
module hazard_detect #(
    parameter int REG_AW = 5
) (
    input  logic              reset,
    input  logic              MemtoRegE,
    input  logic              ValidE,
    input  logic [REG_AW-1:0] RtE,
    input  logic [REG_AW-1:0] RsD,
    input  logic [REG_AW-1:0] RtD,
    input  logic              HoldE,
    output logic              lwstall,
    output logic              StallF,
    output logic              StallD
);

    // ValidE keeps a bubble's zeroed RtE from matching register 0 in decode.
    assign lwstall = MemtoRegE & ValidE & ((RtE == RsD) | (RtE == RtD));

    always_comb begin
        StallF = 1'b0;
        StallD = 1'b0;
        if (!reset) begin
            StallF = lwstall | HoldE;
            StallD = lwstall | HoldE;
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, flush and hold.
// Optional bubble/hold counters are built when STALL_CNT_EN is defined.
module id_ex_stage
    import mips_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              RegWriteD,
    input  logic              MemtoRegD,
    input  logic              MemWriteD,
    input  logic              ALUSrcD,
    input  logic              RegDstD,
    input  logic              BranchD,
    input  logic [2:0]        ALUControlD,
    input  logic [DATA_W-1:0] RD1D,
    input  logic [DATA_W-1:0] RD2D,
    input  logic [DATA_W-1:0] SignImmD,
    input  logic [REG_AW-1:0] RsD,
    input  logic [REG_AW-1:0] RtD,
    input  logic [REG_AW-1:0] RdD,
    input  logic              FlushE,
    input  logic              HoldE,
    output logic              RegWriteE,
    output logic              MemtoRegE,
    output logic              MemWriteE,
    output logic              ALUSrcE,
    output logic              RegDstE,
    output logic              ValidE,
    output logic [2:0]        ALUControlE,
    output logic [DATA_W-1:0] RD1E,
    output logic [DATA_W-1:0] RD2E,
    output logic [DATA_W-1:0] SignImmE,
    output logic [REG_AW-1:0] RsE,
    output logic [REG_AW-1:0] RtE,
    output logic [REG_AW-1:0] RdE,
    output logic [REG_AW-1:0] WriteRegE,
    output logic              StallF,
    output logic              StallD
`ifdef STALL_CNT_EN
    ,
    output logic [31:0]       BubbleCnt,
    output logic [31:0]       HoldCnt
`endif
);

    ctrl_t             ctrl_e;
    logic              valid_e;
    logic [DATA_W-1:0] rd1_e, rd2_e, imm_e;
    logic [REG_AW-1:0] rs_e, rt_e, rd_e;
    logic              lwstall;
    logic              load_bubble;
    // Branch resolution happens elsewhere; the bit plays no part in stalling.
    logic              unused_branch;

    assign unused_branch = BranchD;
    assign load_bubble   = ~HoldE & (FlushE | lwstall);

    hazard_detect #(.REG_AW(REG_AW)) u_hazard (
        .reset     (reset),
        .MemtoRegE (ctrl_e.mem_to_reg),
        .ValidE    (valid_e),
        .RtE       (rt_e),
        .RsD       (RsD),
        .RtD       (RtD),
        .HoldE     (HoldE),
        .lwstall   (lwstall),
        .StallF    (StallF),
        .StallD    (StallD)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ctrl_e  <= CTRL_BUBBLE;
            valid_e <= 1'b0;
            rd1_e   <= '0;
            rd2_e   <= '0;
            imm_e   <= '0;
            rs_e    <= '0;
            rt_e    <= '0;
            rd_e    <= '0;
        end else if (!HoldE) begin
            if (load_bubble) begin
                ctrl_e  <= CTRL_BUBBLE;
                valid_e <= 1'b0;
                rd1_e   <= '0;
                rd2_e   <= '0;
                imm_e   <= '0;
                rs_e    <= '0;
                rt_e    <= '0;
                rd_e    <= '0;
            end else begin
                ctrl_e  <= '{reg_write:  RegWriteD,
                             mem_to_reg: MemtoRegD,
                             mem_write:  MemWriteD,
                             alu_src:    ALUSrcD,
                             reg_dst:    RegDstD,
                             alu_op:     alu_op_e'(ALUControlD)};
                valid_e <= 1'b1;
                rd1_e   <= RD1D;
                rd2_e   <= RD2D;
                imm_e   <= SignImmD;
                rs_e    <= RsD;
                rt_e    <= RtD;
                rd_e    <= RdD;
            end
        end
    end

`ifdef STALL_CNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            BubbleCnt <= '0;
            HoldCnt   <= '0;
        end else begin
            if (load_bubble && BubbleCnt != '1)
                BubbleCnt <= BubbleCnt + 32'd1;
            if (HoldE && HoldCnt != '1)
                HoldCnt <= HoldCnt + 32'd1;
        end
    end
`endif

    assign RegWriteE   = ctrl_e.reg_write;
    assign MemtoRegE   = ctrl_e.mem_to_reg;
    assign MemWriteE   = ctrl_e.mem_write;
    assign ALUSrcE     = ctrl_e.alu_src;
    assign RegDstE     = ctrl_e.reg_dst;
    assign ALUControlE = ctrl_e.alu_op;
    assign ValidE      = valid_e;
    assign RD1E        = rd1_e;
    assign RD2E        = rd2_e;
    assign SignImmE    = imm_e;
    assign RsE         = rs_e;
    assign RtE         = rt_e;
    assign RdE         = rd_e;
    assign WriteRegE   = ctrl_e.reg_dst ? rd_e : rt_e;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed hazard scenarios plus random traffic
// against a rule-level model of the E stage. Counter checks need STALL_CNT_EN.
module tb_id_ex_stage;

    localparam int DW = 32;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          reset;
    logic          RegWriteD, MemtoRegD, MemWriteD, ALUSrcD, RegDstD, BranchD;
    logic [2:0]    ALUControlD;
    logic [DW-1:0] RD1D, RD2D, SignImmD;
    logic [AW-1:0] RsD, RtD, RdD;
    logic          FlushE, HoldE;
    logic          RegWriteE, MemtoRegE, MemWriteE, ALUSrcE, RegDstE, ValidE;
    logic [2:0]    ALUControlE;
    logic [DW-1:0] RD1E, RD2E, SignImmE;
    logic [AW-1:0] RsE, RtE, RdE, WriteRegE;
    logic          StallF, StallD;
`ifdef STALL_CNT_EN
    logic [31:0]   BubbleCnt, HoldCnt;
`endif

    always #5 clk = ~clk;

    id_ex_stage #(.DATA_W(DW), .REG_AW(AW)) dut (
        .clk(clk), .reset(reset),
        .RegWriteD(RegWriteD), .MemtoRegD(MemtoRegD), .MemWriteD(MemWriteD),
        .ALUSrcD(ALUSrcD), .RegDstD(RegDstD), .BranchD(BranchD),
        .ALUControlD(ALUControlD), .RD1D(RD1D), .RD2D(RD2D), .SignImmD(SignImmD),
        .RsD(RsD), .RtD(RtD), .RdD(RdD), .FlushE(FlushE), .HoldE(HoldE),
        .RegWriteE(RegWriteE), .MemtoRegE(MemtoRegE), .MemWriteE(MemWriteE),
        .ALUSrcE(ALUSrcE), .RegDstE(RegDstE), .ValidE(ValidE),
        .ALUControlE(ALUControlE), .RD1E(RD1E), .RD2E(RD2E), .SignImmE(SignImmE),
        .RsE(RsE), .RtE(RtE), .RdE(RdE), .WriteRegE(WriteRegE),
        .StallF(StallF), .StallD(StallD)
`ifdef STALL_CNT_EN
        , .BubbleCnt(BubbleCnt), .HoldCnt(HoldCnt)
`endif
    );

    // What the E stage should hold, as one record; a bubble is all zeros.
    typedef struct packed {
        logic          rw, m2r, mw, as, rdst, v;
        logic [2:0]    alu;
        logic [DW-1:0] rd1, rd2, imm;
        logic [AW-1:0] rs, rt, rd;
    } e_t;

    e_t          me;
    e_t          snap;
    int unsigned bc, hc;
    int          checks = 0;
    int          errors = 0;

    function automatic e_t observed();
        return {RegWriteE, MemtoRegE, MemWriteE, ALUSrcE, RegDstE, ValidE,
                ALUControlE, RD1E, RD2E, SignImmE, RsE, RtE, RdE};
    endfunction

    function automatic e_t d_in();
        return {RegWriteD, MemtoRegD, MemWriteD, ALUSrcD, RegDstD, 1'b1,
                ALUControlD, RD1D, RD2D, SignImmD, RsD, RtD, RdD};
    endfunction

    function automatic logic model_lw();
        return me.m2r && me.v && (me.rt == RsD || me.rt == RtD);
    endfunction

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_stall();
        logic exp;
        exp = !reset && (model_lw() || HoldE);
        check("stallF", 128'(StallF), 128'(exp));
        check("stallD", 128'(StallD), 128'(exp));
    endtask

    task automatic check_e();
        check("e_regs", 128'(observed()), 128'(me));
        check("writereg", 128'(WriteRegE), 128'(me.rdst ? me.rd : me.rt));
    endtask

    // One clock: stall check before the edge, model update at the edge, E check after.
    task automatic cycle();
        logic lw;
        #1 check_stall();
        lw = model_lw();
        @(posedge clk);
        if (reset) begin
            me = '0; bc = 0; hc = 0;
        end else if (HoldE) begin
            if (hc != 32'hFFFF_FFFF) hc++;
        end else if (FlushE || lw) begin
            me = '0;
            if (bc != 32'hFFFF_FFFF) bc++;
        end else begin
            me = d_in();
        end
        #1 check_e();
    endtask

    task automatic set_d(input logic rw, m2r, mw, as, rdst, input logic [2:0] alu,
                         input logic [DW-1:0] rd1, rd2, imm, input logic [AW-1:0] rs, rt, rd);
        RegWriteD = rw; MemtoRegD = m2r; MemWriteD = mw; ALUSrcD = as; RegDstD = rdst;
        BranchD = 1'b0; ALUControlD = alu; RD1D = rd1; RD2D = rd2; SignImmD = imm;
        RsD = rs; RtD = rt; RdD = rd;
    endtask

    task automatic rand_d();
        {RegWriteD, MemtoRegD, MemWriteD, ALUSrcD, RegDstD, BranchD} = 6'($urandom);
        ALUControlD = 3'($urandom);
        RD1D = $urandom; RD2D = $urandom; SignImmD = $urandom;
        RsD = AW'($urandom_range(0, 3));
        RtD = AW'($urandom_range(0, 3));
        RdD = AW'($urandom_range(0, 31));
    endtask

    task automatic check_counts(input string tag);
`ifdef STALL_CNT_EN
        check({tag, "_bubble_cnt"}, 128'(BubbleCnt), 128'(bc));
        check({tag, "_hold_cnt"}, 128'(HoldCnt), 128'(hc));
`endif
    endtask

    initial begin
        reset = 1'b1; HoldE = 1'b1; FlushE = 1'b0;
        rand_d();
        me = '0; bc = 0; hc = 0;
        #1 check_stall();
        @(posedge clk);
        #1 check_e();
        check_stall();
        check_counts("reset");

        // Release: zeroed E must not stall on RtD == 0.
        reset = 1'b0; HoldE = 1'b0;
        set_d(0, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0, 0);
        cycle();

        // add r3, r1, r2
        set_d(1, 0, 0, 0, 1, 3'b010, 5, 7, 0, 1, 2, 3);
        cycle();
        check("add_rd1", 128'(RD1E), 128'd5);
        check("add_rd2", 128'(RD2E), 128'd7);
        check("add_wreg", 128'(WriteRegE), 128'd3);
        check("add_valid", 128'(ValidE), 128'd1);

        // lw r4, 16(r2) followed by a consumer of r4
        set_d(1, 1, 0, 1, 0, 3'b010, 9, 0, 16, 2, 4, 0);
        cycle();
        set_d(1, 0, 0, 0, 1, 3'b010, 1, 1, 0, 4, 5, 6);
        #1 check("lu_stallF", 128'(StallF), 128'd1);
        check("lu_stallD", 128'(StallD), 128'd1);
        cycle();
        check("lu_valid", 128'(ValidE), 128'd0);
        check("lu_regwrite", 128'(RegWriteE), 128'd0);
        check("lu_stall_clear", 128'(StallF), 128'd0);
        cycle();

        // Flush a store
        set_d(0, 0, 1, 1, 0, 3'b010, 3, 4, 8, 1, 2, 0);
        FlushE = 1'b1;
        cycle();
        check("flush_memwrite", 128'(MemWriteE), 128'd0);
        check("flush_valid", 128'(ValidE), 128'd0);
        FlushE = 1'b0;

        // Hold for three edges with flush pending and changing inputs
        set_d(1, 0, 0, 0, 1, 3'b110, 11, 12, 0, 7, 8, 9);
        cycle();
        snap = me;
        HoldE = 1'b1; FlushE = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rand_d();
            cycle();
            check("hold_e", 128'(observed()), 128'(snap));
            check("hold_stallD", 128'(StallD), 128'd1);
        end
        HoldE = 1'b0;
        cycle();
        FlushE = 1'b0;

        // Flush and load-use together give a single bubble
        set_d(1, 1, 0, 1, 0, 3'b010, 9, 0, 4, 2, 4, 0);
        cycle();
        set_d(1, 0, 0, 0, 1, 3'b000, 1, 2, 0, 4, 4, 10);
        FlushE = 1'b1;
        cycle();
        check("fl_lw_valid0", 128'(ValidE), 128'd0);
        FlushE = 1'b0;
        cycle();
        check("fl_lw_valid1", 128'(ValidE), 128'd1);

        for (int i = 0; i < 400; i++) begin
            rand_d();
            HoldE  = ($urandom_range(0, 5) == 0);
            FlushE = ($urandom_range(0, 7) == 0);
            cycle();
        end
        check_counts("random");

        // Asynchronous reset mid-hold with a load in E
        HoldE = 1'b0; FlushE = 1'b0;
        set_d(1, 1, 0, 1, 0, 3'b010, 9, 0, 4, 2, 4, 0);
        cycle();
        HoldE = 1'b1;
        rand_d();
        #2 reset = 1'b1;
        me = '0; bc = 0; hc = 0;
        #1 check("async_rst_e", 128'(observed()), 128'd0);
        check_stall();
        check_counts("async_rst");
        cycle();
        reset = 1'b0; HoldE = 1'b0;
        set_d(0, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0, 0);
        #1 check("post_rst_stallD", 128'(StallD), 128'd0);
        cycle();

        // Two load-use bubbles then three hold edges
        for (int i = 0; i < 2; i++) begin
            set_d(1, 1, 0, 1, 0, 3'b010, 9, 0, 4, 2, 4, 0);
            cycle();
            set_d(1, 0, 0, 0, 1, 3'b010, 1, 1, 0, 4, 5, 6);
            cycle();
        end
        HoldE = 1'b1;
        for (int i = 0; i < 3; i++) cycle();
        HoldE = 1'b0;
        check_counts("lu_hold");
`ifdef STALL_CNT_EN
        check("bubble_cnt_2", 128'(BubbleCnt), 128'd2);
        check("hold_cnt_3", 128'(HoldCnt), 128'd3);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
